clkgen_ctrl: RTL and testbench

CLKGEN_CTRL -- requirements
Module: clkgen_ctrl

---
 rtl/clkgen_pkg.sv | 17 +
 rtl/clkgen_ctrl_if.sv | 34 +++
 rtl/clkgen_timer.sv | 32 +++
 rtl/clkgen_ctrl.sv | 166 ++++++++++++++++
 tb/tb_clkgen_ctrl.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/clkgen_pkg.sv
// rtl/clkgen_pkg.sv - shared types and default widths for the clock generator
// Purpose: FSM state type and default counter widths used by clkgen_ctrl,
//          its bus interface and its timer.
// Ports:   none (package).
package clkgen_pkg;

  localparam int CNT_W_DEF  = 8;
  localparam int NCYC_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PHASE = 2'd1,
    ST_HIGH  = 2'd2,
    ST_LOW   = 2'd3
  } state_e;

endpackage

// File: rtl/clkgen_ctrl_if.sv
// rtl/clkgen_ctrl_if.sv - config, control and status bundle of the clock generator
// Purpose: groups config writes, start/stop strobes and waveform/status outputs.
// Modports: master (drives cfg_*/start/stop, observes outputs),
//           slave  (the generator itself).
interface clkgen_ctrl_if
  import clkgen_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int NCYC_W = NCYC_W_DEF
) ();

  logic              cfg_valid;
  logic [CNT_W-1:0]  cfg_phase;
  logic [CNT_W-1:0]  cfg_ton;
  logic [CNT_W-1:0]  cfg_toff;
  logic [NCYC_W-1:0] cfg_nper;
  logic              start;
  logic              stop;
  logic              wave_out;
  logic              busy;
  logic              done;
  logic [NCYC_W-1:0] per_cnt;

  modport master (
    output cfg_valid, cfg_phase, cfg_ton, cfg_toff, cfg_nper, start, stop,
    input  wave_out, busy, done, per_cnt
  );

  modport slave (
    input  cfg_valid, cfg_phase, cfg_ton, cfg_toff, cfg_nper, start, stop,
    output wave_out, busy, done, per_cnt
  );

endinterface

// File: rtl/clkgen_timer.sv
// rtl/clkgen_timer.sv - loadable down-counter shared by the PHASE/HIGH/LOW states
// Purpose: counts a loaded value down to zero and holds there; tc_o marks the
//          last cycle of the interval (value zero).
// Ports:   clk, rst (sync, active high), load_i (load strobe),
//          load_val_i (value to load: interval length minus one), tc_o.
module clkgen_timer
  import clkgen_pkg::*;
#(
  parameter int W = CNT_W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         tc_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/clkgen_ctrl.sv
// rtl/clkgen_ctrl.sv - programmable phase/high/low waveform generator
// Purpose: after start, waits cfg_phase cycles, then emits ton-high/toff-low
//          periods until cfg_nper periods complete (0 = forever) or stop.
// Ports:   clk, rst (sync, active high), bus (clkgen_ctrl_if.slave:
//          cfg_*/start/stop in, wave_out/busy/done/per_cnt out).
module clkgen_ctrl
  import clkgen_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int NCYC_W = NCYC_W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  clkgen_ctrl_if.slave bus
);

  state_e            state_q, state_d;
  logic              wave_q, wave_d;
  logic              done_q, done_d;
  logic [NCYC_W-1:0] per_cnt_q;
  logic [NCYC_W-1:0] per_next;
  logic              per_inc, per_clr;

  logic [CNT_W-1:0]  shd_phase_q, shd_ton_q, shd_toff_q;
  logic [NCYC_W-1:0] shd_nper_q;
  logic [CNT_W-1:0]  act_ton_q, act_toff_q;
  logic [NCYC_W-1:0] act_nper_q;
  logic              act_load;

  // A write in the same cycle as a start or boundary must already count,
  // so the values loaded into the active set bypass the shadow flops.
  logic [CNT_W-1:0]  eff_phase, eff_ton, eff_toff;
  logic [NCYC_W-1:0] eff_nper;

  logic              tmr_load;
  logic [CNT_W-1:0]  tmr_val;
  logic              tmr_tc;

  assign eff_phase = bus.cfg_valid ? bus.cfg_phase : shd_phase_q;
  assign eff_ton   = bus.cfg_valid ? bus.cfg_ton   : shd_ton_q;
  assign eff_toff  = bus.cfg_valid ? bus.cfg_toff  : shd_toff_q;
  assign eff_nper  = bus.cfg_valid ? bus.cfg_nper  : shd_nper_q;
  assign per_next  = per_cnt_q + NCYC_W'(1);

  // Interval length minus one, with a zero length treated as one cycle.
  function automatic logic [CNT_W-1:0] len_m1(input logic [CNT_W-1:0] n);
    return (n == '0) ? '0 : n - CNT_W'(1);
  endfunction

  clkgen_timer #(.W(CNT_W)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .tc_o       (tmr_tc)
  );

  always_comb begin
    state_d  = state_q;
    wave_d   = 1'b0;
    done_d   = 1'b0;
    tmr_load = 1'b0;
    tmr_val  = '0;
    act_load = 1'b0;
    per_inc  = 1'b0;
    per_clr  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start && !bus.stop) begin
          act_load = 1'b1;
          per_clr  = 1'b1;
          tmr_load = 1'b1;
          if (eff_phase != '0) begin
            state_d = ST_PHASE;
            tmr_val = eff_phase - CNT_W'(1);
          end else begin
            state_d = ST_HIGH;
            tmr_val = len_m1(eff_ton);
          end
        end
      end
      ST_PHASE: begin
        if (tmr_tc) begin
          state_d  = ST_HIGH;
          tmr_load = 1'b1;
          tmr_val  = len_m1(act_ton_q);
        end
      end
      ST_HIGH: begin
        // wave_out follows the state one cycle late, so every interval
        // keeps its length and the output is a plain flop.
        wave_d = 1'b1;
        if (tmr_tc) begin
          state_d  = ST_LOW;
          tmr_load = 1'b1;
          tmr_val  = len_m1(act_toff_q);
        end
      end
      ST_LOW: begin
        if (tmr_tc) begin
          per_inc = 1'b1;
          if (act_nper_q != '0 && per_next == act_nper_q) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d  = ST_HIGH;
            act_load = 1'b1;
            tmr_load = 1'b1;
            tmr_val  = len_m1(eff_ton);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (bus.stop && state_q != ST_IDLE) begin
      state_d  = ST_IDLE;
      wave_d   = 1'b0;
      done_d   = 1'b0;
      tmr_load = 1'b0;
      act_load = 1'b0;
      per_inc  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      wave_q      <= 1'b0;
      done_q      <= 1'b0;
      per_cnt_q   <= '0;
      shd_phase_q <= '0;
      shd_ton_q   <= '0;
      shd_toff_q  <= '0;
      shd_nper_q  <= '0;
      act_ton_q   <= '0;
      act_toff_q  <= '0;
      act_nper_q  <= '0;
    end else begin
      state_q <= state_d;
      wave_q  <= wave_d;
      done_q  <= done_d;
      if (per_clr) begin
        per_cnt_q <= '0;
      end else if (per_inc) begin
        per_cnt_q <= per_next;
      end
      if (bus.cfg_valid) begin
        shd_phase_q <= bus.cfg_phase;
        shd_ton_q   <= bus.cfg_ton;
        shd_toff_q  <= bus.cfg_toff;
        shd_nper_q  <= bus.cfg_nper;
      end
      if (act_load) begin
        act_ton_q  <= eff_ton;
        act_toff_q <= eff_toff;
        act_nper_q <= eff_nper;
      end
    end
  end

  assign bus.wave_out = wave_q;
  assign bus.busy     = (state_q != ST_IDLE);
  assign bus.done     = done_q;
  assign bus.per_cnt  = per_cnt_q;

endmodule

// File: tb/tb_clkgen_ctrl.sv
// tb/tb_clkgen_ctrl.sv - self-checking bench for clkgen_ctrl
module tb_clkgen_ctrl;

  logic clk;
  logic rst;

  clkgen_ctrl_if #(.CNT_W(8), .NCYC_W(16)) cif ();

  clkgen_ctrl #(.CNT_W(8), .NCYC_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (cif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int ec = 0;

  // Reference: a run is a sequence of periods described by the edge after
  // which wave_out first reads 1 (m_rise) and the high/low lengths.
  bit m_run, m_wave, m_done;
  int m_per, m_rise, m_hi, m_lo, m_nper;
  int sh_ph, sh_ton, sh_toff, sh_np;

  logic [31:0] wave_h [int];
  logic [31:0] busy_h [int];
  logic [31:0] done_h [int];
  logic [31:0] per_h  [int];

  function automatic int max1(input int v);
    return (v == 0) ? 1 : v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", name, ec, act, exp);
    end
  endtask

  always @(posedge clk) begin
    int e_ph, e_ton, e_toff, e_np;
    ec++;
    if (rst) begin
      m_run = 0; m_done = 0; m_per = 0;
      sh_ph = 0; sh_ton = 0; sh_toff = 0; sh_np = 0;
    end else begin
      e_ph   = cif.cfg_valid ? int'(cif.cfg_phase) : sh_ph;
      e_ton  = cif.cfg_valid ? int'(cif.cfg_ton)   : sh_ton;
      e_toff = cif.cfg_valid ? int'(cif.cfg_toff)  : sh_toff;
      e_np   = cif.cfg_valid ? int'(cif.cfg_nper)  : sh_np;
      m_done = 0;
      if (m_run) begin
        if (cif.stop) begin
          m_run = 0;
        end else if (ec == m_rise + m_hi + m_lo - 1) begin
          m_per = (m_per + 1) & 32'hFFFF;
          if (m_nper != 0 && m_per == m_nper) begin
            m_run = 0; m_done = 1;
          end else begin
            m_rise = ec + 1; m_hi = max1(e_ton); m_lo = max1(e_toff); m_nper = e_np;
          end
        end
      end else if (cif.start && !cif.stop) begin
        m_run = 1; m_per = 0;
        m_rise = ec + 1 + e_ph; m_hi = max1(e_ton); m_lo = max1(e_toff); m_nper = e_np;
      end
      if (cif.cfg_valid) begin
        sh_ph = e_ph; sh_ton = e_ton; sh_toff = e_toff; sh_np = e_np;
      end
    end
    m_wave = m_run && (ec >= m_rise) && (ec < m_rise + m_hi);
  end

  always @(negedge clk) begin
    if (ec > 0) begin
      check("wave_out", 32'(cif.wave_out), 32'(m_wave));
      check("busy",     32'(cif.busy),     32'(m_run));
      check("done",     32'(cif.done),     32'(m_done));
      check("per_cnt",  32'(cif.per_cnt),  32'(m_per));
      wave_h[ec] = 32'(cif.wave_out);
      busy_h[ec] = 32'(cif.busy);
      done_h[ec] = 32'(cif.done);
      per_h[ec]  = 32'(cif.per_cnt);
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_in();
    cif.cfg_valid = 1'b0;
    cif.start     = 1'b0;
    cif.stop      = 1'b0;
  endtask

  task automatic write_cfg(input int ph, input int ton, input int toff, input int np);
    cif.cfg_valid = 1'b1;
    cif.cfg_phase = 8'(ph);
    cif.cfg_ton   = 8'(ton);
    cif.cfg_toff  = 8'(toff);
    cif.cfg_nper  = 16'(np);
  endtask

  task automatic do_start(output int s);
    cif.start = 1'b1;
    tick();
    s = ec;
    cif.start = 1'b0;
  endtask

  task automatic do_stop();
    cif.stop = 1'b1;
    tick();
    cif.stop = 1'b0;
    tick();
  endtask

  initial begin
    int s, t, z;
    rst = 1'b1;
    idle_in();
    write_cfg(0, 0, 0, 0);
    cif.cfg_valid = 1'b0;
    tick();
    tick();
    check("rst_wave", 32'(cif.wave_out), 32'd0);
    check("rst_busy", 32'(cif.busy), 32'd0);
    check("rst_done", 32'(cif.done), 32'd0);
    check("rst_per",  32'(cif.per_cnt), 32'd0);
    rst = 1'b0;
    tick();

    // phase 7, 5 high / 5 low, continuous
    write_cfg(7, 5, 5, 0); tick(); idle_in();
    do_start(s);
    repeat (30) tick();
    check("p7_pre_rise",  wave_h[s+7],  32'd0);
    check("p7_rise",      wave_h[s+8],  32'd1);
    check("p7_high_end",  wave_h[s+12], 32'd1);
    check("p7_fall",      wave_h[s+13], 32'd0);
    check("p7_low_end",   wave_h[s+17], 32'd0);
    check("p7_rise2",     wave_h[s+18], 32'd1);
    check("p7_busy",      busy_h[s+25], 32'd1);
    do_stop();

    // zero lengths, three periods
    write_cfg(0, 0, 0, 3); tick(); idle_in();
    do_start(s);
    repeat (10) tick();
    check("n3_first_high", wave_h[s+1], 32'd1);
    check("n3_first_low",  wave_h[s+2], 32'd0);
    check("n3_third_high", wave_h[s+5], 32'd1);
    check("n3_busy_last",  busy_h[s+5], 32'd1);
    check("n3_done",       done_h[s+6], 32'd1);
    check("n3_busy_fall",  busy_h[s+6], 32'd0);
    check("n3_per",        per_h[s+6],  32'd3);
    check("n3_done_once",  done_h[s+7], 32'd0);

    // reconfigure mid-HIGH; phase must not come back
    write_cfg(0, 4, 4, 0); tick(); idle_in();
    do_start(s);
    tick();
    write_cfg(3, 2, 6, 0); tick(); idle_in();
    repeat (20) tick();
    check("rc_old_high", wave_h[s+4],  32'd1);
    check("rc_old_low",  wave_h[s+5],  32'd0);
    check("rc_old_lend", wave_h[s+8],  32'd0);
    check("rc_new_rise", wave_h[s+9],  32'd1);
    check("rc_new_high", wave_h[s+10], 32'd1);
    check("rc_new_fall", wave_h[s+11], 32'd0);
    check("rc_new_lend", wave_h[s+16], 32'd0);
    check("rc_rise3",    wave_h[s+17], 32'd1);
    do_stop();

    // stop in the HIGH of the second period
    write_cfg(0, 3, 2, 0); tick(); idle_in();
    do_start(s);
    repeat (5) tick();
    cif.stop = 1'b1; tick(); cif.stop = 1'b0;
    repeat (3) tick();
    check("stp_wave", wave_h[s+6], 32'd0);
    check("stp_busy", busy_h[s+6], 32'd0);
    check("stp_per",  per_h[s+6],  32'd1);
    check("stp_done", done_h[s+6], 32'd0);

    // start+stop together in IDLE, then start while busy
    cif.start = 1'b1; cif.stop = 1'b1; tick(); z = ec; idle_in();
    write_cfg(0, 2, 2, 0); tick(); idle_in();
    do_start(s);
    repeat (2) tick();
    cif.start = 1'b1; tick(); cif.start = 1'b0;
    repeat (6) tick();
    check("ss_idle",       busy_h[z],   32'd0);
    check("rb_busy",       busy_h[s+3], 32'd1);
    check("rb_low_kept",   wave_h[s+4], 32'd0);
    check("rb_rise_kept",  wave_h[s+5], 32'd1);
    do_stop();

    // reset mid-LOW with cfg_valid and start high
    write_cfg(0, 3, 3, 0); tick(); idle_in();
    do_start(s);
    repeat (3) tick();
    rst = 1'b1; write_cfg(2, 9, 9, 1); cif.start = 1'b1;
    tick();
    rst = 1'b0; idle_in();
    tick();
    do_start(t);
    repeat (6) tick();
    check("rl_wave", wave_h[s+4], 32'd0);
    check("rl_busy", busy_h[s+4], 32'd0);
    check("rl_per",  per_h[s+4],  32'd0);
    check("rl_done", done_h[s+4], 32'd0);
    check("rl_h1",   wave_h[t+1], 32'd1);
    check("rl_l1",   wave_h[t+2], 32'd0);
    check("rl_h2",   wave_h[t+3], 32'd1);
    check("rl_l2",   wave_h[t+4], 32'd0);
    do_stop();

    // randomized traffic against the reference
    for (int i = 0; i < 3000; i++) begin
      idle_in();
      rst = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 9) == 0)
        write_cfg($urandom_range(0, 4), $urandom_range(0, 4),
                  $urandom_range(0, 4), $urandom_range(0, 4));
      cif.start = ($urandom_range(0, 19) == 0);
      cif.stop  = ($urandom_range(0, 59) == 0);
      tick();
    end
    rst = 1'b0;
    idle_in();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
